// File: rtl/mem_bist_master.sv
// Memory self-test initiator: writes SEED^addr over a word window, reads it back, counts mismatches.
// Optional `MEM_BIST_INVERT_PASS_EN adds a second write/read pass using the inverted pattern.
module mem_bist_master #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NUM_WORDS  = 64,
    parameter logic [31:0] BASE_ADDR  = 32'h1001_0000,
    parameter logic [31:0] SEED       = 32'hA5A5_5A5A
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  start_i,
    input  logic [DATA_WIDTH-1:0] Read_Data,
    output logic                  Write_Enable_o,
    output logic [31:0]           Address_o,
    output logic [DATA_WIDTH-1:0] Write_Data_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  pass_o,
    output logic [15:0]           err_count_o,
    output logic [31:0]           fail_addr_o
);

`ifdef MEM_BIST_INVERT_PASS_EN
    typedef enum logic [2:0] {
        S_IDLE, S_WRITE, S_READ, S_DONE, S_WRITE2, S_READ2
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE, S_WRITE, S_READ, S_DONE
    } state_t;
`endif

    localparam logic [15:0] LAST = 16'(NUM_WORDS - 1);

    function automatic logic [31:0] addr_of(input logic [15:0] i);
        return BASE_ADDR + {14'd0, i, 2'b00};
    endfunction

    function automatic logic [DATA_WIDTH-1:0] pat_of(input logic [31:0] a);
        return DATA_WIDTH'(SEED) ^ DATA_WIDTH'(a);
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    state_t                  state, state_next;
    logic [15:0]             idx, idx_next;
    logic [15:0]             err_next;
    logic [31:0]             fail_next;
    logic [31:0]             addr_next;
    logic [DATA_WIDTH-1:0]   wdata_next;
    logic [DATA_WIDTH-1:0]   exp_data;
    logic                    we_next, busy_next, done_next, pass_next;
    logic                    mismatch;

    always_comb begin
        state_next = state;
        idx_next   = idx;
        err_next   = err_count_o;
        fail_next  = fail_addr_o;
        mismatch   = 1'b0;
        // Address_o already holds addr(idx) during a read cycle, so the pattern derives from it.
        exp_data   = pat_of(Address_o);
`ifdef MEM_BIST_INVERT_PASS_EN
        if (state == S_READ2) exp_data = ~pat_of(Address_o);
`endif

        case (state)
            S_IDLE, S_DONE: begin
                if (start_i) begin
                    state_next = S_WRITE;
                    idx_next   = '0;
                    err_next   = '0;
                    fail_next  = '0;
                end
            end
            S_WRITE: begin
                if (idx == LAST) begin
                    state_next = S_READ;
                    idx_next   = '0;
                end else begin
                    idx_next = idx + 16'd1;
                end
            end
            S_READ: begin
                mismatch = (Read_Data != exp_data);
                if (idx == LAST) begin
`ifdef MEM_BIST_INVERT_PASS_EN
                    state_next = S_WRITE2;
`else
                    state_next = S_DONE;
`endif
                    idx_next = '0;
                end else begin
                    idx_next = idx + 16'd1;
                end
            end
`ifdef MEM_BIST_INVERT_PASS_EN
            S_WRITE2: begin
                if (idx == LAST) begin
                    state_next = S_READ2;
                    idx_next   = '0;
                end else begin
                    idx_next = idx + 16'd1;
                end
            end
            S_READ2: begin
                mismatch = (Read_Data != exp_data);
                if (idx == LAST) begin
                    state_next = S_DONE;
                    idx_next   = '0;
                end else begin
                    idx_next = idx + 16'd1;
                end
            end
`endif
            default: state_next = S_IDLE;
        endcase

        // err_count_o == 0 doubles as "no mismatch seen yet" since the count never wraps.
        if (mismatch) begin
            err_next = sat_inc(err_count_o);
            if (err_count_o == 16'd0) fail_next = Address_o;
        end

        we_next    = 1'b0;
        busy_next  = 1'b0;
        addr_next  = '0;
        wdata_next = Write_Data_o;
        case (state_next)
            S_WRITE: begin
                we_next    = 1'b1;
                busy_next  = 1'b1;
                addr_next  = addr_of(idx_next);
                wdata_next = pat_of(addr_of(idx_next));
            end
            S_READ: begin
                busy_next = 1'b1;
                addr_next = addr_of(idx_next);
            end
`ifdef MEM_BIST_INVERT_PASS_EN
            S_WRITE2: begin
                we_next    = 1'b1;
                busy_next  = 1'b1;
                addr_next  = addr_of(idx_next);
                wdata_next = ~pat_of(addr_of(idx_next));
            end
            S_READ2: begin
                busy_next = 1'b1;
                addr_next = addr_of(idx_next);
            end
`endif
            default: ;
        endcase

        done_next = (state_next == S_DONE);
        pass_next = done_next && (err_next == 16'd0);
    end

    // Registered state and outputs
    always_ff @(posedge CLK) begin
        if (RST) begin
            state          <= S_IDLE;
            idx            <= '0;
            Write_Enable_o <= 1'b0;
            Address_o      <= '0;
            Write_Data_o   <= '0;
            busy_o         <= 1'b0;
            done_o         <= 1'b0;
            pass_o         <= 1'b0;
            err_count_o    <= '0;
            fail_addr_o    <= '0;
        end else begin
            state          <= state_next;
            idx            <= idx_next;
            Write_Enable_o <= we_next;
            Address_o      <= addr_next;
            Write_Data_o   <= wdata_next;
            busy_o         <= busy_next;
            done_o         <= done_next;
            pass_o         <= pass_next;
            err_count_o    <= err_next;
            fail_addr_o    <= fail_next;
        end
    end

endmodule

// File: tb/tb_mem_bist_master.sv
// Bench for mem_bist_master: RAM model with stuck-at faults, write scoreboard and result queue.
module tb_mem_bist_master;
    localparam int          NW    = 4;
    localparam logic [31:0] BASE  = 32'h1001_0000;
    localparam logic [31:0] SEEDV = 32'hA5A5_5A5A;
`ifdef MEM_BIST_INVERT_PASS_EN
    localparam int PASSES = 2;
`else
    localparam int PASSES = 1;
`endif
    localparam int RUN_LEN = 2 * PASSES * NW;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        start_i = 1'b0;
    logic [31:0] Read_Data;
    logic        Write_Enable_o;
    logic [31:0] Address_o;
    logic [31:0] Write_Data_o;
    logic        busy_o, done_o, pass_o;
    logic [15:0] err_count_o;
    logic [31:0] fail_addr_o;

    mem_bist_master #(
        .DATA_WIDTH(32), .NUM_WORDS(NW), .BASE_ADDR(BASE), .SEED(SEEDV)
    ) dut (
        .CLK(CLK), .RST(RST), .start_i(start_i), .Read_Data(Read_Data),
        .Write_Enable_o(Write_Enable_o), .Address_o(Address_o), .Write_Data_o(Write_Data_o),
        .busy_o(busy_o), .done_o(done_o), .pass_o(pass_o),
        .err_count_o(err_count_o), .fail_addr_o(fail_addr_o)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        string             name;
        logic [3:0][31:0]  stuck1;
        logic [3:0][31:0]  stuck0;
        logic [15:0]       exp_err;
        logic [31:0]       exp_fail;
        logic              exp_pass;
    } vec_t;

    typedef struct { logic [31:0] addr; logic [31:0] data; } wr_t;
    typedef struct { logic [15:0] err; logic [31:0] fail; logic pass; } res_t;

    wr_t  wr_q[$];
    res_t res_q[$];

    logic [31:0]      mem [NW];
    logic [3:0][31:0] stuck1, stuck0;
    logic             in_win;
    logic [31:0]      offs;
    int               widx;
    int               n_checks = 0;
    int               n_fail = 0;

    always_comb begin
        offs      = Address_o - BASE;
        in_win    = (Address_o >= BASE) && (offs < 32'(4 * NW));
        widx      = int'(offs >> 2);
        Read_Data = 32'd0;
        if (in_win) Read_Data = (mem[widx] | stuck1[widx]) & ~stuck0[widx];
    end

    always @(posedge CLK) begin
        if (Write_Enable_o === 1'b1 && in_win) mem[widx] <= Write_Data_o;
    end

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endfunction

    // Every write the DUT issues must match the next expected write.
    always @(negedge CLK) begin
        if (Write_Enable_o === 1'b1) begin
            if (wr_q.size() == 0) begin
                chk("write_unexpected", Address_o, 32'hFFFF_FFFF);
            end else begin
                wr_t w;
                w = wr_q.pop_front();
                chk("write_addr", Address_o, w.addr);
                chk("write_data", Write_Data_o, w.data);
            end
        end
    end

    task automatic push_writes();
        for (int p = 0; p < PASSES; p++) begin
            for (int i = 0; i < NW; i++) begin
                wr_t w;
                w.addr = BASE + 32'(4 * i);
                w.data = SEEDV ^ w.addr;
                if (p == 1) w.data = ~w.data;
                wr_q.push_back(w);
            end
        end
    endtask

    // Called at a negedge; inject >= 0 pulses start_i during the run at that cycle.
    task automatic do_run(input string name, input logic [15:0] e_err, input logic [31:0] e_fail,
                          input logic e_pass, input int inject);
        int   cnt;
        bit   seen;
        res_t r;
        push_writes();
        r.err = e_err; r.fail = e_fail; r.pass = e_pass;
        res_q.push_back(r);
        start_i = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        start_i = 1'b0;
        chk({name, "_busy0"}, 32'(busy_o), 32'd1);
        chk({name, "_done0"}, 32'(done_o), 32'd0);
        chk({name, "_first_data"}, Write_Data_o, 32'hB5A4_5A5A);
        cnt = 0;
        seen = 0;
        while (!seen && cnt < 200) begin
            @(posedge CLK);
            cnt++;
            @(negedge CLK);
            start_i = (cnt == inject);
            if (done_o === 1'b1) seen = 1;
        end
        start_i = 1'b0;
        chk({name, "_run_len"}, 32'(cnt), 32'(RUN_LEN));
        if (res_q.size() == 0) begin
            chk({name, "_res_missing"}, 32'd0, 32'd1);
        end else begin
            r = res_q.pop_front();
            chk({name, "_err"}, 32'(err_count_o), 32'(r.err));
            chk({name, "_fail_addr"}, fail_addr_o, r.fail);
            chk({name, "_pass"}, 32'(pass_o), 32'(r.pass));
            chk({name, "_busy_end"}, 32'(busy_o), 32'd0);
            chk({name, "_we_end"}, 32'(Write_Enable_o), 32'd0);
        end
        chk({name, "_writes_left"}, 32'(wr_q.size()), 32'd0);
    endtask

    vec_t vecs[5];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{"ideal", '0, '0, 16'd0, 32'd0, 1'b1};
        vecs[1] = '{"stuck_w2", {32'd0, 32'd1, 32'd0, 32'd0}, '0, 16'd1, 32'h1001_0008, 1'b0};
        vecs[2] = '{"stuck_w1w3", {32'd1, 32'd0, 32'd1, 32'd0}, '0, 16'd2, 32'h1001_0004, 1'b0};
        vecs[3] = '{"bit31_low", '0, {4{32'h8000_0000}}, 16'd4, 32'h1001_0000, 1'b0};
        vecs[4] = '{"stuck_w3b16", {32'h0001_0000, 32'd0, 32'd0, 32'd0}, '0, 16'd1, 32'h1001_000C, 1'b0};
        stuck1 = '0;
        stuck0 = '0;
        for (int i = 0; i < NW; i++) mem[i] = 32'd0;

        repeat (2) @(posedge CLK);
        @(negedge CLK);
        chk("rst_we", 32'(Write_Enable_o), 32'd0);
        chk("rst_addr", Address_o, 32'd0);
        chk("rst_wdata", Write_Data_o, 32'd0);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_done", 32'(done_o), 32'd0);
        chk("rst_pass", 32'(pass_o), 32'd0);
        chk("rst_err", 32'(err_count_o), 32'd0);
        chk("rst_fail", fail_addr_o, 32'd0);
        RST = 1'b0;
        @(negedge CLK);

        for (int v = 0; v < 5; v++) begin
            stuck1 = vecs[v].stuck1;
            stuck0 = vecs[v].stuck0;
            do_run(vecs[v].name, vecs[v].exp_err, vecs[v].exp_fail, vecs[v].exp_pass, -1);
        end

        // start_i during READ is ignored; then restart from DONE
        stuck1 = vecs[1].stuck1;
        stuck0 = '0;
        do_run("start_in_read", 16'd1, 32'h1001_0008, 1'b0, NW + 1);
        do_run("restart_done", 16'd1, 32'h1001_0008, 1'b0, -1);

        // reset during the third write cycle
        stuck1 = '0;
        push_writes();
        start_i = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        start_i = 1'b0;
        @(posedge CLK);
        @(negedge CLK);
        @(posedge CLK);
        @(negedge CLK);
        chk("abort_third_write_addr", Address_o, BASE + 32'd8);
        RST = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        chk("abort_we", 32'(Write_Enable_o), 32'd0);
        chk("abort_busy", 32'(busy_o), 32'd0);
        chk("abort_done", 32'(done_o), 32'd0);
        chk("abort_err", 32'(err_count_o), 32'd0);
        chk("abort_addr", Address_o, 32'd0);
        wr_q.delete();
        @(posedge CLK);
        @(negedge CLK);
        chk("abort_idle_busy", 32'(busy_o), 32'd0);
        chk("abort_idle_we", 32'(Write_Enable_o), 32'd0);
        do_run("after_abort", 16'd0, 32'd0, 1'b1, -1);

        chk("results_left", 32'(res_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
